memory_arbiter: RTL

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 62 ++++++
 rtl/memory_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/memory_arbiter_if.sv
// Bus bundle for memory_arbiter: fetch port, data port,
// memory side and status. slave = arbiter, master = environment.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface memory_arbiter_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH
);
  logic                  fetchReq;
  logic [DATA_WIDTH-1:0] fetchAddress;
  logic                  fetchGrant;
  logic                  fetchDone;
  logic [DATA_WIDTH-1:0] fetchData;

  logic                  dataReq;
  logic [DATA_WIDTH-1:0] dataAddress;
  logic [DATA_WIDTH-1:0] dataWrite;
  logic [1:0]            dataLength;
  logic                  dataStore;
  logic                  dataLoadUnsigned;
  logic                  dataGrant;
  logic                  dataDone;
  logic [DATA_WIDTH-1:0] dataRead;

  logic [DATA_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memDataWrite;
  logic [1:0]            memLength;
  logic                  memStore;
  logic                  memLoad;
  logic                  memLoadUnsigned;
  logic                  memAck;
  logic [DATA_WIDTH-1:0] memDataRead;

  logic                  busy;
  logic                  owner;
  logic                  timeoutError;

  modport slave (
    input  fetchReq, fetchAddress,
    output fetchGrant, fetchDone, fetchData,
    input  dataReq, dataAddress, dataWrite,
    input  dataLength, dataStore, dataLoadUnsigned,
    output dataGrant, dataDone, dataRead,
    output memAddress, memDataWrite, memLength,
    output memStore, memLoad, memLoadUnsigned,
    input  memAck, memDataRead,
    output busy, owner, timeoutError
  );

  modport master (
    output fetchReq, fetchAddress,
    input  fetchGrant, fetchDone, fetchData,
    output dataReq, dataAddress, dataWrite,
    output dataLength, dataStore, dataLoadUnsigned,
    input  dataGrant, dataDone, dataRead,
    input  memAddress, memDataWrite, memLength,
    input  memStore, memLoad, memLoadUnsigned,
    output memAck, memDataRead,
    input  busy, owner, timeoutError
  );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port (fetch/data) single-memory arbiter, IDLE/BUSY/RESP FSM.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is data-priority.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module memory_arbiter #(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic           clk,
  input logic           reset,
  memory_arbiter_if.slave bus
);
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_M1 =
    (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_M1[CW-1:0];

  state_t        state;
  logic [CW-1:0] count;
  logic          pickData;
  logic          expire;
  word_t         respData;

`ifdef ARB_ROUND_ROBIN_EN
  logic lastOwner;

  always_comb begin
    pickData = bus.dataReq;
    if (bus.fetchReq && bus.dataReq) pickData = ~lastOwner;
  end
`else
  always_comb begin
    pickData = bus.dataReq;
  end
`endif

  // count holds BUSY cycles already elapsed without memAck
  assign expire = (TIMEOUT_CYCLES != 0) && (count == TO_LAST);
  assign respData = (bus.memAck && bus.memLoad) ?
                    bus.memDataRead : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      count               <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      lastOwner           <= 1'b1;
`endif
      bus.fetchGrant      <= 1'b0;
      bus.fetchDone       <= 1'b0;
      bus.fetchData       <= '0;
      bus.dataGrant       <= 1'b0;
      bus.dataDone        <= 1'b0;
      bus.dataRead        <= '0;
      bus.memAddress      <= '0;
      bus.memDataWrite    <= '0;
      bus.memLength       <= 2'b00;
      bus.memStore        <= 1'b0;
      bus.memLoad         <= 1'b0;
      bus.memLoadUnsigned <= 1'b0;
      bus.busy            <= 1'b0;
      bus.owner           <= 1'b0;
      bus.timeoutError    <= 1'b0;
    end else begin
      bus.fetchGrant   <= 1'b0;
      bus.dataGrant    <= 1'b0;
      bus.fetchDone    <= 1'b0;
      bus.dataDone     <= 1'b0;
      bus.timeoutError <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.fetchReq || bus.dataReq) begin
            state     <= BUSY;
            count     <= '0;
            bus.busy  <= 1'b1;
            bus.owner <= pickData;
`ifdef ARB_ROUND_ROBIN_EN
            lastOwner <= pickData;
`endif
            if (pickData) begin
              bus.dataGrant       <= 1'b1;
              bus.memAddress      <= bus.dataAddress;
              bus.memDataWrite    <= bus.dataWrite;
              bus.memLength       <= bus.dataLength;
              bus.memStore        <= bus.dataStore;
              bus.memLoad         <= ~bus.dataStore;
              bus.memLoadUnsigned <= bus.dataLoadUnsigned;
            end else begin
              bus.fetchGrant      <= 1'b1;
              bus.memAddress      <= bus.fetchAddress;
              bus.memDataWrite    <= '0;
              bus.memLength       <= 2'b10;
              bus.memStore        <= 1'b0;
              bus.memLoad         <= 1'b1;
              bus.memLoadUnsigned <= 1'b1;
            end
          end
        end
        BUSY: begin
          // memAck beats a simultaneous timeout
          if (bus.memAck || expire) begin
            state            <= RESP;
            bus.memStore     <= 1'b0;
            bus.memLoad      <= 1'b0;
            bus.timeoutError <= ~bus.memAck;
            if (bus.owner) begin
              bus.dataDone <= 1'b1;
              bus.dataRead <= respData;
            end else begin
              bus.fetchDone <= 1'b1;
              bus.fetchData <= respData;
            end
          end else begin
            count <= count + CW'(1);
          end
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
